// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the 2-read/1-write architectural register file.
package reg_file_pkg;

    localparam int RF_WIDTH = 32;
    localparam int RF_DEPTH = 32;
    localparam int RF_AW    = $clog2(RF_DEPTH);

    typedef enum logic {
        RF_CLEAR,
        RF_READY
    } rf_state_e;

    typedef logic [RF_AW-1:0] rf_addr_t;

endpackage

// File: rtl/reg_file_clear_seq.sv
// Post-reset clear sequencer: walks every entry once, one per cycle, then hands the write port back.
module reg_file_clear_seq
    import reg_file_pkg::*;
#(
    parameter int  DEPTH = RF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output logic          state_dbg
);

    rf_state_e     state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == RF_CLEAR) begin
            clr_idx_d = clr_idx_q + 1'b1;
            // The last entry is cleared on the same edge that leaves CLEAR.
            if (clr_idx_q == AW'(DEPTH - 1)) begin
                state_d = RF_READY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RF_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    assign busy      = (state_q == RF_CLEAR);
    assign clr_we    = busy && !reset;
    assign clr_addr  = clr_idx_q;
    assign state_dbg = state_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// Architectural register file feeding ALU SrcA/SrcB: two combinational reads, one clocked write,
// r0 hardwired to zero, optional same-cycle write-to-read bypass.
module reg_file_2r1w
    import reg_file_pkg::*;
#(
    parameter int  WIDTH  = RF_WIDTH,
    parameter int  DEPTH  = RF_DEPTH,
    parameter int  BYPASS = 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    A1,
    input  logic [AW-1:0]    A2,
    input  logic [AW-1:0]    A3,
    input  logic             WE3,
    input  logic [WIDTH-1:0] WD3,
    output logic [WIDTH-1:0] RD1,
    output logic [WIDTH-1:0] RD2,
    output logic             busy
);

    logic             clr_busy;
    logic             clr_we;
    logic [AW-1:0]    clr_addr;
    logic             clr_state;

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] mem_q [DEPTH];

    reg_file_clear_seq #(
        .DEPTH (DEPTH)
    ) u_clear_seq (
        .clk       (clk),
        .reset     (reset),
        .busy      (clr_busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .state_dbg (clr_state)
    );

    // The sequencer owns the single write port while busy; architectural writes are dropped then.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = A3;
        wr_data = WD3;
        if (clr_busy) begin
            wr_en   = clr_we;
            wr_addr = clr_addr;
            wr_data = '0;
        end else if (WE3 && (A3 != '0)) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Forced zero while busy also hides the undefined contents before the first clear completes.
    always_comb begin
        RD1 = '0;
        RD2 = '0;
        if (!clr_busy && (A1 != '0)) begin
            if ((BYPASS != 0) && WE3 && (A3 == A1)) RD1 = WD3;
            else                                    RD1 = mem_q[A1];
        end
        if (!clr_busy && (A2 != '0)) begin
            if ((BYPASS != 0) && WE3 && (A3 == A2)) RD2 = WD3;
            else                                    RD2 = mem_q[A2];
        end
    end

    assign busy = clr_busy;

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (clr_busy == (clr_state == RF_CLEAR));
        end
    end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: one bypassed and one non-bypassed instance share stimulus; a
// behavioural register model fills an expected queue that a negedge monitor drains.
module tb_reg_file_2r1w;
    import reg_file_pkg::*;

    localparam int W  = RF_WIDTH;
    localparam int D  = RF_DEPTH;
    localparam int AW = RF_AW;
    localparam int EW = 2 + 4 * W;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] a1, a2, a3;
    logic          we3;
    logic [W-1:0]  wd3;
    logic [W-1:0]  rd1, rd2, nb_rd1, nb_rd2;
    logic          busy, nb_busy;

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] exp_q [$];
    string         tag_q [$];

    // behavioural model state
    logic [W-1:0] m_mem [D];
    bit           m_busy = 1'b1;
    int           m_clear_left = 0;

    always #5 clk = ~clk;

    reg_file_2r1w #(.WIDTH(W), .DEPTH(D), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .A1(a1), .A2(a2), .A3(a3), .WE3(we3), .WD3(wd3),
        .RD1(rd1), .RD2(rd2), .busy(busy)
    );

    reg_file_2r1w #(.WIDTH(W), .DEPTH(D), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .A1(a1), .A2(a2), .A3(a3), .WE3(we3), .WD3(wd3),
        .RD1(nb_rd1), .RD2(nb_rd2), .busy(nb_busy)
    );

    function automatic logic [W-1:0] model_read(input logic [AW-1:0] a, input bit byp);
        if (m_busy || a == '0) return '0;
        if (byp && we3 && a3 == a) return wd3;
        return m_mem[a];
    endfunction

    // Reset starts a D-cycle clear window; the whole file reads zero once it closes.
    task automatic model_step(input bit rst, input logic [AW-1:0] wa, input bit we,
                              input logic [W-1:0] wd);
        if (rst) begin
            m_busy       = 1'b1;
            m_clear_left = D;
        end else if (m_busy) begin
            m_clear_left--;
            if (m_clear_left == 0) begin
                m_busy = 1'b0;
                for (int i = 0; i < D; i++) m_mem[i] = '0;
            end
        end else if (we && wa != '0) begin
            m_mem[wa] = wd;
        end
    endtask

    task automatic drive(input string tag, input bit rst, input logic [AW-1:0] ra1,
                         input logic [AW-1:0] ra2, input logic [AW-1:0] wa, input bit we,
                         input logic [W-1:0] wd, input bit chk);
        reset = rst;
        a1    = ra1;
        a2    = ra2;
        a3    = wa;
        we3   = we;
        wd3   = wd;
        if (chk) begin
            exp_q.push_back({m_busy, m_busy, model_read(ra1, 1'b1), model_read(ra2, 1'b1),
                             model_read(ra1, 1'b0), model_read(ra2, 1'b0)});
            tag_q.push_back(tag);
        end
        @(posedge clk);
        model_step(rst, wa, we, wd);
        #1;
    endtask

    task automatic rand_cycles(input string tag, input int n, input int reset_odds);
        for (int i = 0; i < n; i++) begin
            drive(tag, (reset_odds > 0) && ($urandom_range(0, reset_odds - 1) == 0),
                  AW'($urandom_range(0, D - 1)), AW'($urandom_range(0, D - 1)),
                  AW'($urandom_range(0, D - 1)), 1'($urandom_range(0, 1)), $urandom, 1'b1);
        end
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [EW-1:0] e;
            string         t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk({t, " busy"},    W'(busy),    W'(e[EW-1]));
            chk({t, " nb_busy"}, W'(nb_busy), W'(e[EW-2]));
            chk({t, " rd1"},     rd1,         e[4*W-1:3*W]);
            chk({t, " rd2"},     rd2,         e[3*W-1:2*W]);
            chk({t, " nb_rd1"},  nb_rd1,      e[2*W-1:W]);
            chk({t, " nb_rd2"},  nb_rd2,      e[W-1:0]);
        end
    end

    initial begin
        // Initial reset; DUT state before it is unknown, so no check on this cycle.
        drive("rst", 1'b1, '0, '0, '0, 1'b0, '0, 1'b0);
        rand_cycles("clear0", D, 0);
        drive("ready0", 1'b0, 5'd1, 5'd31, '0, 1'b0, '0, 1'b1);

        drive("byp_wr", 1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 32'hDEADBEEF, 1'b1);
        drive("byp_rd", 1'b0, 5'd5, 5'd0, '0, 1'b0, '0, 1'b1);

        drive("r0_wr", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 32'hFFFFFFFF, 1'b1);
        drive("r0_rd", 1'b0, 5'd0, 5'd0, '0, 1'b0, '0, 1'b1);

        drive("w7", 1'b0, 5'd7, 5'd9, 5'd7, 1'b1, 32'h12345678, 1'b1);
        drive("w9", 1'b0, 5'd7, 5'd9, 5'd9, 1'b1, 32'h00000001, 1'b1);
        drive("srcab", 1'b0, 5'd7, 5'd9, '0, 1'b0, '0, 1'b1);

        rand_cycles("rand", 400, 150);
        drive("rst_r", 1'b1, '0, '0, '0, 1'b0, '0, 1'b1);
        rand_cycles("clear_r", D, 0);

        drive("w3", 1'b0, 5'd3, 5'd3, 5'd3, 1'b1, 32'hA5A5A5A5, 1'b1);
        drive("rd3", 1'b0, 5'd3, 5'd0, '0, 1'b0, '0, 1'b1);
        drive("rst_ready", 1'b1, 5'd3, 5'd4, '0, 1'b0, '0, 1'b1);
        drive("w4_busy", 1'b0, 5'd4, 5'd3, 5'd4, 1'b1, 32'h00001111, 1'b1);
        rand_cycles("clear1", D - 1, 0);
        drive("rd34", 1'b0, 5'd3, 5'd4, '0, 1'b0, '0, 1'b1);

        for (int i = 1; i < D; i++) begin
            drive("fill", 1'b0, AW'(i), AW'(D - i), AW'(i), 1'b1, $urandom | 32'h1, 1'b1);
        end
        drive("rst_mid", 1'b1, '0, '0, '0, 1'b0, '0, 1'b1);
        rand_cycles("clear2a", 10, 0);
        drive("rst_again", 1'b1, 5'd1, 5'd2, '0, 1'b0, '0, 1'b1);
        rand_cycles("clear2b", D, 0);
        for (int i = 1; i < D; i++) begin
            drive("zero_all", 1'b0, AW'(i), AW'(D - i), '0, 1'b0, '0, 1'b1);
        end

        drive("drain", 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
